// File: rtl/traffic_pkg.sv
// Shared definitions for the four-way traffic controller slice.
// Contents: congestion level codes, lane indices, light encodings and the
// queue-length quantiser used by the lane density encoder.
package traffic_pkg;

  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MED  = 2'd2,
    LVL_HIGH = 2'd3
  } level_e;

  localparam int unsigned LANE_A = 0;
  localparam int unsigned LANE_B = 1;
  localparam int unsigned LANE_C = 2;
  localparam int unsigned LANE_D = 3;

  typedef enum logic [2:0] {
    GREEN  = 3'b001,
    ORANGE = 3'b010,
    RED    = 3'b100
  } light_e;

  // Map a queue length onto a congestion level given ascending thresholds.
  function automatic level_e quantise(input int unsigned n,
                                      input int unsigned t1,
                                      input int unsigned t2,
                                      input int unsigned t3);
    if (n >= t3)      return LVL_HIGH;
    else if (n >= t2) return LVL_MED;
    else if (n >= t1) return LVL_LOW;
    else              return LVL_NONE;
  endfunction

endpackage

// File: rtl/lane_density_encoder_if.sv
// Signal bundle between the lane density encoder and its environment.
// master: detector/control side (drives arr_raw, dep_raw, clr_ovf).
// slave : encoder side (drives Sa..Sd, queue_len, ovf, sample_tick).
interface lane_density_encoder_if #(
  parameter int unsigned QW = 6
) ();
  logic [3:0]      arr_raw;
  logic [3:0]      dep_raw;
  logic            clr_ovf;
  logic [1:0]      Sa;
  logic [1:0]      Sb;
  logic [1:0]      Sc;
  logic [1:0]      Sd;
  logic [4*QW-1:0] queue_len;
  logic [3:0]      ovf;
  logic            sample_tick;

  modport master (
    output arr_raw, dep_raw, clr_ovf,
    input  Sa, Sb, Sc, Sd, queue_len, ovf, sample_tick
  );

  modport slave (
    input  arr_raw, dep_raw, clr_ovf,
    output Sa, Sb, Sc, Sd, queue_len, ovf, sample_tick
  );
endinterface

// File: rtl/lane_detector_debounce.sv
// One detector channel: 2-flop synchroniser, debounce counter and a
// registered one-cycle pulse on each debounced 0->1 transition.
// Ports: clk, rst_n (async, active-low), raw_i (raw detector line),
//        evt_o (rise event pulse).
module lane_detector_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic evt_o
);
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          evt_q, evt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds the number of prior consecutive differing edges, so the
  // flip happens on the edge where it already reads DEB_CYCLES-1.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    evt_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == LAST) begin
        deb_d = sync2_q;
        evt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign evt_o = evt_q;
endmodule

// File: rtl/lane_density_encoder.sv
// Converts raw per-lane arrival/departure detectors into saturating queue
// counts and hysteretic 2-bit congestion levels, refreshed on a sample tick.
// Ports: clk, rst_n (async, active-low), bus (slave modport):
//   arr_raw/dep_raw[3:0] raw detectors (bit0 = lane A), clr_ovf clears ovf,
//   Sa..Sd levels, queue_len packed counts (A in LSBs), ovf sticky overflow,
//   sample_tick pulse on the cycle levels update.
module lane_density_encoder
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned QW            = 6,
  parameter int unsigned TH1           = 4,
  parameter int unsigned TH2           = 12,
  parameter int unsigned TH3           = 24,
  parameter int unsigned HYST          = 2,
  parameter int unsigned SAMPLE_CYCLES = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  lane_density_encoder_if.slave bus
);
  localparam logic [QW-1:0] QMAX  = '1;
  localparam int unsigned   SW    = $clog2(SAMPLE_CYCLES);
  localparam logic [SW-1:0] SLAST = SW'(SAMPLE_CYCLES - 1);

  logic [3:0]    arr_evt, dep_evt;
  logic [QW-1:0] q_q [4];
  logic [QW-1:0] q_d [4];
  logic [3:0]    ovf_q, ovf_d;
  level_e        lvl_q [4];
  level_e        lvl_d [4];
  logic [SW-1:0] scnt_q;
  logic          tick_q;
  logic          scnt_last;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    lane_detector_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_arr (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (bus.arr_raw[g]),
      .evt_o (arr_evt[g])
    );
    lane_detector_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dep (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_i (bus.dep_raw[g]),
      .evt_o (dep_evt[g])
    );
    assign bus.queue_len[g*QW +: QW] = q_q[g];
  end

  assign scnt_last = (scnt_q == SLAST);

  // A clear and a fresh overflow on the same edge: the set is applied last.
  always_comb begin
    ovf_d = bus.clr_ovf ? '0 : ovf_q;
    for (int unsigned i = 0; i < 4; i++) begin
      q_d[i] = q_q[i];
      case ({arr_evt[i], dep_evt[i]})
        2'b10: begin
          if (q_q[i] != QMAX) q_d[i] = q_q[i] + QW'(1);
          else                ovf_d[i] = 1'b1;
        end
        2'b01: begin
          if (q_q[i] != '0) q_d[i] = q_q[i] - QW'(1);
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // Going down uses the level of count+HYST, so a lane must drop HYST below
  // a threshold before its level falls.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      lvl_d[i] = lvl_q[i];
      if (scnt_last) begin
        if (quantise(32'(q_q[i]), TH1, TH2, TH3) > lvl_q[i])
          lvl_d[i] = quantise(32'(q_q[i]), TH1, TH2, TH3);
        else if (quantise(32'(q_q[i]), TH1, TH2, TH3) < lvl_q[i])
          lvl_d[i] = quantise(32'(q_q[i]) + HYST, TH1, TH2, TH3);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        q_q[i]   <= '0;
        lvl_q[i] <= LVL_NONE;
      end
      ovf_q  <= '0;
      scnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        q_q[i]   <= q_d[i];
        lvl_q[i] <= lvl_d[i];
      end
      ovf_q  <= ovf_d;
      scnt_q <= scnt_last ? '0 : scnt_q + SW'(1);
      tick_q <= scnt_last;
    end
  end

  assign bus.Sa          = lvl_q[LANE_A];
  assign bus.Sb          = lvl_q[LANE_B];
  assign bus.Sc          = lvl_q[LANE_C];
  assign bus.Sd          = lvl_q[LANE_D];
  assign bus.ovf         = ovf_q;
  assign bus.sample_tick = tick_q;
endmodule

// File: tb/tb_lane_density_encoder.sv
// Directed bench for lane_density_encoder with hand-computed expectations.
module tb_lane_density_encoder;
  logic clk;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  lane_density_encoder_if #(.QW(6)) bus ();

  lane_density_encoder #(
    .DEB_CYCLES    (4),
    .QW            (6),
    .TH1           (4),
    .TH2           (12),
    .TH3           (24),
    .HYST          (2),
    .SAMPLE_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qlen(input int unsigned lane);
    logic [23:0] v;
    v = bus.queue_len;
    return 32'(v[lane*6 +: 6]);
  endfunction

  // n clean detector pulses on the given lane masks.
  task automatic pulse(input logic [3:0] a, input logic [3:0] d, input int unsigned n);
    repeat (n) begin
      bus.arr_raw = a;
      bus.dep_raw = d;
      step(8);
      bus.arr_raw = '0;
      bus.dep_raw = '0;
      step(8);
    end
  endtask

  task automatic wait_tick();
    int unsigned n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.sample_tick && n < 40);
    check_eq("wait_tick", 32'(bus.sample_tick), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_qlen"}, 32'(bus.queue_len), 32'd0);
    check_eq({tag, "_ovf"},  32'(bus.ovf), 32'd0);
    check_eq({tag, "_lvls"}, {24'd0, bus.Sa, bus.Sb, bus.Sc, bus.Sd}, 32'd0);
    check_eq({tag, "_tick"}, 32'(bus.sample_tick), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.arr_raw = '0;
    bus.dep_raw = '0;
    bus.clr_ovf = 1'b0;
    step(2);
    check_all_zero("rst");
    rst_n = 1'b1;

    // First tick SAMPLE_CYCLES edges after release.
    step(15);
    check_eq("tick_early", 32'(bus.sample_tick), 32'd0);
    step(1);
    check_eq("tick_first", 32'(bus.sample_tick), 32'd1);
    step(1);
    check_eq("tick_pulse", 32'(bus.sample_tick), 32'd0);

    // Glitch of 3 cycles on lane A is rejected.
    bus.arr_raw = 4'b0001;
    step(3);
    bus.arr_raw = '0;
    step(12);
    check_eq("glitch_qA", qlen(0), 32'd0);

    // Held rise: count changes at edge 7, not 6, and only once.
    bus.arr_raw = 4'b0001;
    step(6);
    check_eq("lat_edge6_qA", qlen(0), 32'd0);
    step(1);
    check_eq("lat_edge7_qA", qlen(0), 32'd1);
    step(3);
    bus.arr_raw = '0;
    step(10);
    check_eq("once_qA", qlen(0), 32'd1);

    // Saturation on lane B.
    pulse(4'b0010, 4'b0000, 70);
    check_eq("sat_qB", qlen(1), 32'd63);
    check_eq("sat_ovf", 32'(bus.ovf), 32'h2);
    check_eq("sat_qA", qlen(0), 32'd1);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    check_eq("clr_ovf", 32'(bus.ovf), 32'h0);
    // Overflow set lands on the same edge as clr_ovf.
    bus.arr_raw = 4'b0010;
    step(6);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    check_eq("set_wins_ovf", 32'(bus.ovf), 32'h2);
    step(1);
    bus.arr_raw = '0;
    step(8);

    // Lane C simultaneous events; lane D underflow.
    pulse(4'b0100, 4'b0000, 5);
    check_eq("qC_5", qlen(2), 32'd5);
    pulse(4'b0100, 4'b0100, 1);
    check_eq("simul_qC", qlen(2), 32'd5);
    pulse(4'b0000, 4'b0100, 1);
    check_eq("dep_qC", qlen(2), 32'd4);
    pulse(4'b0000, 4'b1000, 2);
    check_eq("under_qD", qlen(3), 32'd0);
    check_eq("under_ovf", 32'(bus.ovf), 32'h2);
    wait_tick();
    check_eq("lvl_Sb", 32'(bus.Sb), 32'd3);
    check_eq("lvl_Sc", 32'(bus.Sc), 32'd1);
    check_eq("lvl_Sd", 32'(bus.Sd), 32'd0);

    // Hysteresis on lane A.
    pulse(4'b0001, 4'b0000, 11);
    check_eq("hy_qA12", qlen(0), 32'd12);
    wait_tick();
    check_eq("hy_Sa12", 32'(bus.Sa), 32'd2);
    pulse(4'b0000, 4'b0001, 1);
    wait_tick();
    check_eq("hy_Sa11", 32'(bus.Sa), 32'd2);
    pulse(4'b0000, 4'b0001, 1);
    wait_tick();
    check_eq("hy_Sa10", 32'(bus.Sa), 32'd2);
    pulse(4'b0000, 4'b0001, 1);
    check_eq("hy_qA9", qlen(0), 32'd9);
    wait_tick();
    check_eq("hy_Sa9", 32'(bus.Sa), 32'd1);
    pulse(4'b0001, 4'b0000, 15);
    check_eq("hy_qA24", qlen(0), 32'd24);
    wait_tick();
    check_eq("hy_Sa24", 32'(bus.Sa), 32'd3);

    // Count change between ticks becomes visible only at the next tick.
    pulse(4'b1000, 4'b0000, 3);
    wait_tick();
    check_eq("st_Sd3", 32'(bus.Sd), 32'd0);
    bus.arr_raw = 4'b1000;
    step(8);
    check_eq("st_qD4", qlen(3), 32'd4);
    check_eq("st_Sd_hold", 32'(bus.Sd), 32'd0);
    bus.arr_raw = '0;
    step(7);
    check_eq("st_tick_low", 32'(bus.sample_tick), 32'd0);
    check_eq("st_Sd_hold2", 32'(bus.Sd), 32'd0);
    step(1);
    check_eq("st_tick_16", 32'(bus.sample_tick), 32'd1);
    check_eq("st_Sd_upd", 32'(bus.Sd), 32'd1);
    step(8);

    // Reset mid-operation with a partial debounce pending.
    check_eq("pre_rst_Sa", 32'(bus.Sa), 32'd3);
    bus.arr_raw = 4'b0001;
    step(3);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    bus.arr_raw = '0;
    step(3);
    rst_n = 1'b1;
    step(15);
    check_eq("rr_tick_early", 32'(bus.sample_tick), 32'd0);
    step(1);
    check_eq("rr_tick_first", 32'(bus.sample_tick), 32'd1);
    step(10);
    check_eq("rr_qlen", 32'(bus.queue_len), 32'd0);
    check_eq("rr_ovf", 32'(bus.ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
